// File: rtl/pmod_sample_sequencer.sv
// Sample-rate scheduler for the AD1 ADC / DA3 DAC chain: one AD1 read followed by one
// DA3 write per sample tick, both clocked from a single shared SCLK.
module pmod_sample_sequencer #(
   parameter int CLK_DIV    = 4,
   parameter int SAMPLE_DIV = 2000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic [1:0]  ch_mode,
   input  logic        adc_d0,
   input  logic        adc_d1,
   output logic        adc_cs_n,
   output logic        adc_sclk,
   output logic        dac_cs_n,
   output logic        dac_sclk,
   output logic        dac_din,
   output logic        dac_ldac_n,
   output logic [11:0] sample_out,
   output logic        sample_ch,
   output logic        sample_valid,
   output logic        overrun,
   output logic        busy
);

   localparam int DIV_W  = $clog2(CLK_DIV);
   localparam int TICK_W = $clog2(SAMPLE_DIV);
   localparam int LDAC_W = $clog2(2 * CLK_DIV);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
   localparam logic [LDAC_W-1:0] LDAC_LAST = LDAC_W'(2 * CLK_DIV - 1);

   typedef enum logic [2:0] {IDLE, START, ADC, SCALE, DAC, LDAC} state_t;

   logic [DIV_W-1:0]  divCnt_q, divCnt_d;
   logic              sclk_q;
   logic              divTerm, riseEvt, fallEvt;
   logic [TICK_W-1:0] tickCnt_q, tickCnt_d;
   logic              tickTerm, tick_q;

   state_t            state_q;
   logic [11:0]       shift_q;
   logic [15:0]       word_q;
   logic [4:0]        bitCnt_q;
   logic [LDAC_W-1:0] ldacCnt_q;
   logic              enLat_q, chSel_q, altMode_q, chPtr_q;
   logic              adcCs_q, dacCs_q, dacDin_q, ldac_q;
   logic [11:0]       sample_q;
   logic              sampleCh_q, valid_q, overrun_q, busy_q;

   // The rise/fall strobes are high in the cycle before sclk changes, so every FSM
   // action they trigger lands on the same clock edge as the SCLK transition.
   assign divTerm  = (divCnt_q == DIV_LAST);
   assign divCnt_d = divTerm ? '0 : divCnt_q + 1'b1;
   assign riseEvt  = divTerm & ~sclk_q;
   assign fallEvt  = divTerm & sclk_q;

   assign tickTerm  = (tickCnt_q == TICK_LAST);
   assign tickCnt_d = tickTerm ? '0 : tickCnt_q + 1'b1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         divCnt_q  <= '0;
         sclk_q    <= 1'b1;
         tickCnt_q <= '0;
         tick_q    <= 1'b0;
      end else begin
         divCnt_q  <= divCnt_d;
         tickCnt_q <= tickCnt_d;
         tick_q    <= tickTerm;
         if (divTerm) begin
            sclk_q <= ~sclk_q;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         word_q     <= '0;
         bitCnt_q   <= '0;
         ldacCnt_q  <= '0;
         enLat_q    <= 1'b0;
         chSel_q    <= 1'b0;
         altMode_q  <= 1'b0;
         chPtr_q    <= 1'b0;
         adcCs_q    <= 1'b1;
         dacCs_q    <= 1'b1;
         dacDin_q   <= 1'b0;
         ldac_q     <= 1'b1;
         sample_q   <= '0;
         sampleCh_q <= 1'b0;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (tick_q) begin
            if (state_q != IDLE) begin
               overrun_q <= 1'b1;
            end else if (!enable) begin
               overrun_q <= 1'b0;
            end
         end

         case (state_q)
            IDLE: begin
               if (tick_q) begin
                  enLat_q   <= enable;
                  altMode_q <= (ch_mode == 2'b10);
                  chSel_q   <= (ch_mode == 2'b01) | ((ch_mode == 2'b10) & chPtr_q);
                  busy_q    <= 1'b1;
                  state_q   <= START;
               end
            end

            START: begin
               if (riseEvt) begin
                  bitCnt_q <= '0;
                  if (enLat_q) begin
                     adcCs_q <= 1'b0;
                     state_q <= ADC;
                  end else begin
                     word_q  <= '0;
                     state_q <= DAC;
                  end
               end
            end

            // Only 12 bits are kept; the AD1's four leading zeros fall off the top.
            ADC: begin
               if (riseEvt) begin
                  shift_q <= {shift_q[10:0], (chSel_q ? adc_d1 : adc_d0)};
                  if (bitCnt_q == 5'd15) begin
                     adcCs_q <= 1'b1;
                     state_q <= SCALE;
                  end else begin
                     bitCnt_q <= bitCnt_q + 1'b1;
                  end
               end
            end

            SCALE: begin
               sample_q   <= shift_q;
               sampleCh_q <= chSel_q;
               valid_q    <= 1'b1;
               word_q     <= {shift_q, shift_q[11:8]};
               bitCnt_q   <= '0;
               if (altMode_q) begin
                  chPtr_q <= ~chPtr_q;
               end
               state_q <= DAC;
            end

            // Seventeen falling edges: sixteen present data bits, the last closes the frame.
            DAC: begin
               if (fallEvt) begin
                  if (bitCnt_q == 5'd16) begin
                     dacCs_q   <= 1'b1;
                     dacDin_q  <= 1'b0;
                     ldac_q    <= 1'b0;
                     ldacCnt_q <= '0;
                     state_q   <= LDAC;
                  end else begin
                     dacCs_q  <= 1'b0;
                     dacDin_q <= word_q[15];
                     word_q   <= {word_q[14:0], 1'b0};
                     bitCnt_q <= bitCnt_q + 1'b1;
                  end
               end
            end

            LDAC: begin
               if (ldacCnt_q == LDAC_LAST) begin
                  ldac_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  ldacCnt_q <= ldacCnt_q + 1'b1;
               end
            end

            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign adc_cs_n     = adcCs_q;
   assign adc_sclk     = sclk_q;
   assign dac_cs_n     = dacCs_q;
   assign dac_sclk     = sclk_q;
   assign dac_din      = dacDin_q;
   assign dac_ldac_n   = ldac_q;
   assign sample_out   = sample_q;
   assign sample_ch    = sampleCh_q;
   assign sample_valid = valid_q;
   assign overrun      = overrun_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_pmod_sample_sequencer.sv
// Directed bench for pmod_sample_sequencer: an AD1 data model feeds the ADC lines and a
// DA3 model reassembles each DAC frame; a second instance runs with a short tick period.
module tb_pmod_sample_sequencer;

   localparam int CD     = 2;
   localparam int SD     = 200;
   localparam int SD_OVR = 100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstMain, rstOvr;
   logic        enable, ovrEnable;
   logic [1:0]  chMode, ovrChMode;
   logic        adcD0, adcD1, ovrD0, ovrD1;

   logic        adcCsN, adcSclk, dacCsN, dacSclk, dacDin, ldacN;
   logic [11:0] sampleOut;
   logic        sampleCh, sampleValid, overrunFlag, busy;

   logic        ovrAdcCsN, ovrAdcSclk, ovrDacCsN, ovrDacSclk, ovrDacDin, ovrLdacN;
   logic [11:0] ovrSampleOut;
   logic        ovrSampleCh, ovrValid, ovrOverrun, ovrBusy;

   pmod_sample_sequencer #(.CLK_DIV(CD), .SAMPLE_DIV(SD)) dut (
      .clock(clk), .reset(rstMain), .enable(enable), .ch_mode(chMode),
      .adc_d0(adcD0), .adc_d1(adcD1),
      .adc_cs_n(adcCsN), .adc_sclk(adcSclk),
      .dac_cs_n(dacCsN), .dac_sclk(dacSclk), .dac_din(dacDin), .dac_ldac_n(ldacN),
      .sample_out(sampleOut), .sample_ch(sampleCh), .sample_valid(sampleValid),
      .overrun(overrunFlag), .busy(busy)
   );

   pmod_sample_sequencer #(.CLK_DIV(CD), .SAMPLE_DIV(SD_OVR)) dutOvr (
      .clock(clk), .reset(rstOvr), .enable(ovrEnable), .ch_mode(ovrChMode),
      .adc_d0(ovrD0), .adc_d1(ovrD1),
      .adc_cs_n(ovrAdcCsN), .adc_sclk(ovrAdcSclk),
      .dac_cs_n(ovrDacCsN), .dac_sclk(ovrDacSclk), .dac_din(ovrDacDin), .dac_ldac_n(ovrLdacN),
      .sample_out(ovrSampleOut), .sample_ch(ovrSampleCh), .sample_valid(ovrValid),
      .overrun(ovrOverrun), .busy(ovrBusy)
   );

   int checks   = 0;
   int failures = 0;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Clock edges since the main instance left reset; read on the falling edge it equals
   // the number of the rising edge just passed.
   int cyc;
   always @(posedge clk or negedge rstMain) begin
      if (!rstMain) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   // AD1 model: a new bit appears on each SCLK fall while CS is low, MSB first.
   logic [15:0] adcWord0, adcWord1, adcSh0, adcSh1;
   always @(negedge adcSclk) begin
      if (!adcCsN) begin
         adcD0  = adcSh0[15];
         adcD1  = adcSh1[15];
         adcSh0 = {adcSh0[14:0], 1'b0};
         adcSh1 = {adcSh1[14:0], 1'b0};
      end else begin
         adcSh0 = adcWord0;
         adcSh1 = adcWord1;
      end
   end

   // DA3 model: latch on SCLK rise while CS is low; a whole frame is 16 bits.
   logic [15:0] dacShift;
   int          dacBits  = 0;
   int          lastBits = 0;
   logic [31:0] dacFrameQ[$];
   always @(posedge dacSclk) begin
      if (!dacCsN) begin
         dacShift = {dacShift[14:0], dacDin};
         dacBits++;
      end
   end
   always @(posedge dacCsN) begin
      if (dacBits == 16) dacFrameQ.push_back({16'h0, dacShift});
      lastBits = dacBits;
      dacBits  = 0;
   end

   logic [15:0] ovrShift;
   int          ovrBits      = 0;
   int          ovrAdcFrames = 0;
   logic [31:0] ovrFrameQ[$];
   always @(posedge ovrDacSclk) begin
      if (!ovrDacCsN) begin
         ovrShift = {ovrShift[14:0], ovrDacDin};
         ovrBits++;
      end
   end
   always @(posedge ovrDacCsN) begin
      if (ovrBits == 16) ovrFrameQ.push_back({16'h0, ovrShift});
      ovrBits = 0;
   end
   always @(negedge ovrAdcCsN) ovrAdcFrames++;

   // Pulse-width and event monitor, sampled mid-cycle.
   logic [31:0] validQ[$], validCycQ[$], adcFallQ[$], adcWidthQ[$], dacWidthQ[$], ldacWidthQ[$];
   int   adcLow = 0, dacLow = 0, ldacLow = 0;
   logic adcCsPrev = 1'b1;
   always @(negedge clk) begin
      if (sampleValid) begin
         validQ.push_back({19'h0, sampleCh, sampleOut});
         validCycQ.push_back(cyc);
      end
      if (!adcCsN && adcCsPrev) adcFallQ.push_back(cyc);
      adcCsPrev = adcCsN;
      if (!adcCsN) adcLow++;
      else if (adcLow != 0) begin adcWidthQ.push_back(adcLow); adcLow = 0; end
      if (!dacCsN) dacLow++;
      else if (dacLow != 0) begin dacWidthQ.push_back(dacLow); dacLow = 0; end
      if (!ldacN) ldacLow++;
      else if (ldacLow != 0) begin ldacWidthQ.push_back(ldacLow); ldacLow = 0; end
   end

   task automatic clearMonitors();
      validQ.delete(); validCycQ.delete(); adcFallQ.delete();
      adcWidthQ.delete(); dacWidthQ.delete(); ldacWidthQ.delete(); dacFrameQ.delete();
   endtask

   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(negedge clk);
   endtask

   // Checks the one transaction expected since the monitors were last cleared.
   task automatic checkTransaction(input string tag, input logic [31:0] expSample, input logic [31:0] expWord);
      checkOutput({tag, ".validCount"}, validQ.size(), 1);
      checkOutput({tag, ".sample"}, (validQ.size() > 0) ? validQ.pop_front() : 32'hDEADBEEF, expSample);
      checkOutput({tag, ".frameCount"}, dacFrameQ.size(), 1);
      checkOutput({tag, ".dacWord"}, (dacFrameQ.size() > 0) ? dacFrameQ.pop_front() : 32'hDEADBEEF, expWord);
      checkOutput({tag, ".adcCsLow"}, (adcWidthQ.size() > 0) ? adcWidthQ.pop_front() : 32'hDEADBEEF, 64);
      checkOutput({tag, ".ldacLow"}, (ldacWidthQ.size() > 0) ? ldacWidthQ.pop_front() : 32'hDEADBEEF, 4);
   endtask

   logic [31:0] expSample, expWord;

   initial begin
      rstMain = 1'b0; rstOvr = 1'b0;
      enable = 1'b1; chMode = 2'b00; ovrEnable = 1'b1; ovrChMode = 2'b00;
      adcD0 = 1'b0; adcD1 = 1'b0; ovrD0 = 1'b1; ovrD1 = 1'b0;
      adcWord0 = 16'h0ABC; adcWord1 = 16'h0000;
      applyStimulus(3);

      checkOutput("rst.adc_cs_n", adcCsN, 1);
      checkOutput("rst.dac_cs_n", dacCsN, 1);
      checkOutput("rst.ldac_n", ldacN, 1);
      checkOutput("rst.sclk", {adcSclk, dacSclk}, 2'b11);
      checkOutput("rst.dac_din", dacDin, 0);
      checkOutput("rst.sample", {sampleCh, sampleValid, sampleOut}, 0);
      checkOutput("rst.flags", {overrunFlag, busy}, 0);

      // Basic pass-through: first tick registers after edge 200, FSM leaves IDLE on 201,
      // CS falls on the rise at 204, sample_valid follows the 16th rise at 268.
      clearMonitors();
      rstMain = 1'b1;
      applyStimulus(SD);
      checkOutput("basic.busyBeforeTick", busy, 0);
      applyStimulus(1);
      checkOutput("basic.busyAfterTick", busy, 1);
      applyStimulus(149);
      checkOutput("basic.adcCsFallCycle", (adcFallQ.size() > 0) ? adcFallQ.pop_front() : 32'hDEADBEEF, 204);
      checkOutput("basic.validCycle", (validCycQ.size() > 0) ? validCycQ.pop_front() : 32'hDEADBEEF, 269);
      checkOutput("basic.dacCsLow", (dacWidthQ.size() > 0) ? dacWidthQ.pop_front() : 32'hDEADBEEF, 64);
      checkOutput("basic.busyIdle", busy, 0);
      checkTransaction("basic", 32'h0ABC, 32'hABCA);

      clearMonitors();
      adcWord0 = 16'h0FFF;
      applyStimulus(SD);
      checkTransaction("full", 32'h0FFF, 32'hFFFF);

      clearMonitors();
      adcWord0 = 16'h0000;
      applyStimulus(SD);
      checkTransaction("zero", 32'h0000, 32'h0000);

      // Alternating channels; on the second tick the inputs are disturbed mid-frame.
      chMode = 2'b10; adcWord0 = 16'h0123; adcWord1 = 16'h0456;
      for (int i = 0; i < 4; i++) begin
         clearMonitors();
         if (i == 1) begin
            applyStimulus(100);
            enable = 1'b0; chMode = 2'b01;
            applyStimulus(100);
            enable = 1'b1; chMode = 2'b10;
         end else begin
            applyStimulus(SD);
         end
         expSample = (i % 2 == 1) ? 32'h1456 : 32'h0123;
         expWord   = (i % 2 == 1) ? 32'h4564 : 32'h1231;
         checkTransaction($sformatf("alt%0d", i), expSample, expWord);
      end

      clearMonitors();
      chMode = 2'b11; adcWord0 = 16'h0321; adcWord1 = 16'h0654;
      applyStimulus(SD);
      checkTransaction("mode11", 32'h0321, 32'h3213);

      // Disabled: two ticks, no ADC activity, a zero DAC frame with LDAC each time.
      clearMonitors();
      enable = 1'b0; chMode = 2'b00;
      applyStimulus(2 * SD);
      checkOutput("dis.validCount", validQ.size(), 0);
      checkOutput("dis.adcFrames", adcFallQ.size(), 0);
      checkOutput("dis.frameCount", dacFrameQ.size(), 2);
      for (int i = 0; i < 2; i++) begin
         checkOutput($sformatf("dis.dacWord%0d", i), (dacFrameQ.size() > 0) ? dacFrameQ.pop_front() : 32'hDEADBEEF, 0);
         checkOutput($sformatf("dis.ldacLow%0d", i), (ldacWidthQ.size() > 0) ? ldacWidthQ.pop_front() : 32'hDEADBEEF, 4);
         checkOutput($sformatf("dis.dacCsLow%0d", i), (dacWidthQ.size() > 0) ? dacWidthQ.pop_front() : 32'hDEADBEEF, 64);
      end
      checkOutput("dis.overrun", overrunFlag, 0);

      // Reset during the DAC frame, after nine bits have been latched by the DA3.
      clearMonitors();
      enable = 1'b1; adcWord0 = 16'h0ABC;
      applyStimulus(155);
      checkOutput("rmid.dacCsLowBefore", dacCsN, 0);
      checkOutput("rmid.busyBefore", busy, 1);
      #1 rstMain = 1'b0;
      #1;
      checkOutput("rmid.dac_cs_n", dacCsN, 1);
      checkOutput("rmid.ldac_n", ldacN, 1);
      checkOutput("rmid.dac_din", dacDin, 0);
      checkOutput("rmid.busy", busy, 0);
      checkOutput("rmid.sample_out", sampleOut, 0);
      checkOutput("rmid.partialBits", lastBits, 9);
      checkOutput("rmid.noFrame", dacFrameQ.size(), 0);
      checkOutput("rmid.noLdac", ldacWidthQ.size(), 0);
      @(negedge clk);
      rstMain = 1'b1;
      applyStimulus(SD);
      checkOutput("rmid.busyBeforeTick", busy, 0);
      applyStimulus(1);
      checkOutput("rmid.busyAfterTick", busy, 1);
      applyStimulus(149);
      checkOutput("rmid.recoverWord", (dacFrameQ.size() > 0) ? dacFrameQ.pop_front() : 32'hDEADBEEF, 32'hABCA);

      // Overrun: a transaction outlasts the 100-clock tick period, so every other tick
      // is dropped; frames start on ticks 1,3,5,7,9 and the ninth ends by edge 1038.
      rstOvr = 1'b1;
      applyStimulus(150);
      checkOutput("ovr.afterFirstTick", ovrOverrun, 0);
      applyStimulus(60);
      checkOutput("ovr.afterSecondTick", ovrOverrun, 1);
      applyStimulus(870);
      checkOutput("ovr.adcFrames", ovrAdcFrames, 5);
      checkOutput("ovr.dacFrames", ovrFrameQ.size(), 5);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("ovr.dacWord%0d", i), (ovrFrameQ.size() > 0) ? ovrFrameQ.pop_front() : 32'hDEADBEEF, 32'hFFFF);
      end
      checkOutput("ovr.sticky", ovrOverrun, 1);
      checkOutput("ovr.sample", {ovrSampleCh, ovrSampleOut}, 13'h0FFF);
      ovrEnable = 1'b0;
      applyStimulus(30);
      checkOutput("ovr.clearedByIdleDisabledTick", ovrOverrun, 0);
      checkOutput("ovr.disabledFrameBusy", ovrBusy, 1);
      checkOutput("ovr.idleStrobes", {ovrValid, ovrLdacN}, 2'b01);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/pmod_sample_sequencer.md
# pmod_sample_sequencer

Sample-rate scheduler for the AD1 ADC / DA3 DAC signal chain: emits a periodic sample tick, runs one AD1 read and then one DA3 write per tick on a shared serial clock, and selects between the two AD1 channels. Sits between the Pmod pins and the Basys 3 top level. Replaces free-running per-converter counters with one deterministic transaction FSM.

## Interface
- `CLK_DIV`, 4: system clocks per SCLK half-period; minimum 2.
- `SAMPLE_DIV`, 2000: system clocks per sample tick; 50 kS/s at 100 MHz.
- `clock`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  SW0; 1 = pass-through, 0 = DAC held at code 0x0000.
- `ch_mode`  in  2  00 = AD1 D0 only; 01 = D1 only; 10 = alternate D0/D1; 11 = treated as 00.
- `adc_d0`, `adc_d1`  in  1 each  AD1 serial data lines.
- `adc_cs_n`, `adc_sclk`  out  1 each  AD1 chip select and serial clock.
- `dac_cs_n`, `dac_sclk`, `dac_din`, `dac_ldac_n`  out  1 each  DA3 serial interface.
- `sample_out`  out  12  last captured ADC code, for the LEDs.
- `sample_ch`  out  1  channel of `sample_out`.
- `sample_valid`  out  1  one-clock pulse when `sample_out` updates.
- `overrun`  out  1  sticky: a tick arrived while the FSM was not IDLE.
- `busy`  out  1  high whenever the FSM is not IDLE.

## Operation
- **Reset values.**
  - `adc_cs_n`, `dac_cs_n`, `dac_ldac_n` = 1.
  - `adc_sclk`, `dac_sclk` = 1; both are driven from one internal `sclk`.
  - `dac_din`, `sample_out`, `sample_ch`, `sample_valid`, `overrun`, `busy` = 0.
  - Tick counter, divider and channel pointer = 0.
- **SCLK generation.**
  - Divider counts 0..CLK_DIV-1; `sclk` toggles at terminal count and runs freely after reset.
  - `rise_evt` / `fall_evt`: internal one-clock strobes on the clock edge where `sclk` goes 1 / 0.
- **Sample tick.** One-clock pulse when the tick counter reaches SAMPLE_DIV-1; the counter then wraps to 0.
- **FSM states:** IDLE, START, ADC, SCALE, DAC, LDAC.
  - IDLE:
    - On tick, latch `enable` and the channel to use; go to START.
    - Channel: from `ch_mode`; in mode 10 it is the pointer value.
  - START:
    - Wait for the next `rise_evt`.
    - If enable was latched, drive `adc_cs_n` = 0 and go to ADC.
    - Otherwise build DAC word 0x0000 and go to DAC, waiting for `fall_evt`.
  - ADC:
    - On each `rise_evt`, shift the selected data line into a 16-bit register, MSB first.
    - On the 16th `rise_evt`: `adc_cs_n` = 1, go to SCALE.
  - SCALE (1 clock):
    - `sample_out` = shift[11:0]; shift[15:12] are the four leading zeros and are discarded.
    - Set `sample_ch`, pulse `sample_valid`, toggle the pointer if in mode 10.
    - DAC word = {code[11:0], code[11:8]}, so 0xFFF maps to 0xFFFF and 0x000 maps to 0x0000.
  - DAC:
    - On the first `fall_evt`, `dac_cs_n` = 0 and `dac_din` = word[15].
    - On each following `fall_evt`, present the next bit; the DAC latches on `rise_evt`.
    - On the `fall_evt` after the 16th `rise_evt`: `dac_cs_n` = 1, `dac_din` = 0, `dac_ldac_n` = 0, go to LDAC.
  - LDAC: hold `dac_ldac_n` = 0 for 2*CLK_DIV clocks, then set it to 1 and go to IDLE.
- **`enable` and `ch_mode` mid-transaction:** ignored; both are sampled only at the tick.
- **Overrun.**
  - A tick outside IDLE is dropped and sets `overrun`.
  - `overrun` clears only on reset or on a tick that finds the FSM in IDLE with `enable` = 0.
- **Reset mid-transaction:** all outputs return immediately to their reset values. A partial DAC frame is abandoned because LDAC is never pulsed.

## Timing
- First tick: SAMPLE_DIV clocks after `reset` deasserts. Tick period is exactly SAMPLE_DIV clocks.
- Tick to ADC start: `adc_cs_n` falls 2..2*CLK_DIV+1 clocks after the tick (rise_evt alignment).
- ADC frame: `adc_cs_n` low for exactly 32*CLK_DIV clocks.
- SCALE: `sample_valid` is high on the clock after `adc_cs_n` rises.
- DAC frame:
  - `dac_cs_n` low for 16 SCLK periods, 32*CLK_DIV clocks.
  - Each `dac_din` bit is stable across its `rise_evt`, changing CLK_DIV clocks before it.
- LDAC: low for 2*CLK_DIV clocks, starting on the clock `dac_cs_n` rises.
- Worst-case transaction: ≤ 74*CLK_DIV+4 clocks. SAMPLE_DIV must be at least 76*CLK_DIV, or `overrun` is expected.

## Test plan
- **Basic pass-through** (CLK_DIV=2, SAMPLE_DIV=200, enable=1, ch_mode=00; `adc_d0` model returns 0x0ABC after four zeros) -> `sample_out`=0xABC, `sample_ch`=0; DAC frame bits 0xABCA; one LDAC pulse of 4 clocks.
- **Full-scale and zero** (codes 0xFFF, then 0x000) -> DAC words 0xFFFF, then 0x0000; `adc_cs_n` low 64 clocks each frame.
- **Alternate channels** (ch_mode=10, D0=0x123, D1=0x456) -> `sample_ch` 0,1,0,1; DAC words 0x1231, 0x4564 alternating.
- **Disabled** (enable=0) -> `adc_cs_n` stays 1, no `sample_valid`, DAC frame 0x0000 every tick, `overrun` cleared.
- **Overrun** (SAMPLE_DIV=100, CLK_DIV=2) -> `overrun`=1 after second tick; dropped ticks start no frames; every DAC frame completes intact.
- **Reset mid-frame** (assert reset after 8th DAC bit) -> same clock: `dac_cs_n`=1, `dac_ldac_n`=1, `dac_din`=0, `busy`=0; first new tick SAMPLE_DIV clocks after release.
